// File: rtl/bitwise_reducer.sv
// Streaming bitwise reducer: folds a packet of WIDTH-bit words with AND/OR/XOR/NAND
// and presents the registered result on a valid/ready handshake.
module bitwise_reducer #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MAX_WORDS = 16,
    localparam int unsigned CNT_W    = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] inData,
    input  logic             inValid,
    input  logic             inLast,
    output logic             inReady,
    output logic [WIDTH-1:0] out,
    output logic             outValid,
    input  logic             outReady,
    output logic [CNT_W-1:0] wordCount,
    output logic             outTrunc
);

    localparam logic [1:0]       MODE_AND    = 2'd0;
    localparam logic [1:0]       MODE_OR     = 2'd1;
    localparam logic [1:0]       MODE_XOR    = 2'd2;
    localparam logic [1:0]       MODE_NAND   = 2'd3;
    localparam logic [CNT_W-1:0] MAX_CNT     = CNT_W'(MAX_WORDS);
    localparam bit               SINGLE_BEAT = (MAX_WORDS == 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] out_d;
    logic             out_valid_d;
    logic [CNT_W-1:0] count_d;
    logic             trunc_d;
    logic             accept;
    logic             close;
    logic             close_trunc;

    // NAND folds as AND; the inversion is applied once when the result is published.
    function automatic logic [WIDTH-1:0] fold(input logic [1:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        case (op)
            MODE_OR:  fold = a | b;
            MODE_XOR: fold = a ^ b;
            default:  fold = a & b;
        endcase
    endfunction

    assign inReady = (state_q != ST_DONE);
    assign accept  = inValid && inReady;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        out_d       = out;
        out_valid_d = outValid;
        count_d     = wordCount;
        trunc_d     = outTrunc;
        close       = 1'b0;
        close_trunc = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mode_d = mode;
                    acc_d  = inData;
                    cnt_d  = CNT_W'(1);
                    if (inLast || SINGLE_BEAT) begin
                        close       = 1'b1;
                        close_trunc = !inLast;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    acc_d = fold(mode_q, acc_q, inData);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (inLast) begin
                        close = 1'b1;
                    end else if (cnt_d == MAX_CNT) begin
                        close       = 1'b1;
                        close_trunc = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (outReady) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Result is published on the same edge that accepts the closing beat
        if (close) begin
            state_d     = ST_DONE;
            out_d       = (mode_d == MODE_NAND) ? ~acc_d : acc_d;
            count_d     = cnt_d;
            trunc_d     = close_trunc;
            out_valid_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            mode_q    <= MODE_AND;
            out       <= '0;
            outValid  <= 1'b0;
            wordCount <= '0;
            outTrunc  <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            out       <= out_d;
            outValid  <= out_valid_d;
            wordCount <= count_d;
            outTrunc  <= trunc_d;
        end
    end

endmodule

// File: tb/tb_bitwise_reducer.sv
// Directed bench for bitwise_reducer (WIDTH=16, MAX_WORDS=4) with hand-computed results.
module tb_bitwise_reducer;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned MAX_WORDS = 4;
    localparam int unsigned CNT_W     = $clog2(MAX_WORDS + 1);

    localparam logic [1:0] M_AND  = 2'd0;
    localparam logic [1:0] M_OR   = 2'd1;
    localparam logic [1:0] M_XOR  = 2'd2;
    localparam logic [1:0] M_NAND = 2'd3;

    logic             clk = 1'b0;
    logic             rstN;
    logic [1:0]       mode;
    logic [WIDTH-1:0] inData;
    logic             inValid;
    logic             inLast;
    logic             inReady;
    logic [WIDTH-1:0] out;
    logic             outValid;
    logic             outReady;
    logic [CNT_W-1:0] wordCount;
    logic             outTrunc;

    int n_tests = 0;
    int n_fail  = 0;

    bitwise_reducer #(
        .WIDTH     (WIDTH),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .mode      (mode),
        .inData    (inData),
        .inValid   (inValid),
        .inLast    (inLast),
        .inReady   (inReady),
        .out       (out),
        .outValid  (outValid),
        .outReady  (outReady),
        .wordCount (wordCount),
        .outTrunc  (outTrunc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [15:0] o,
                                input int unsigned cnt, input logic trunc);
        check({tag, "_valid"}, 32'(outValid), 32'd1);
        check({tag, "_out"},   32'(out), 32'(o));
        check({tag, "_count"}, 32'(wordCount), cnt);
        check({tag, "_trunc"}, 32'(outTrunc), 32'(trunc));
    endtask

    // Present one beat, wait (bounded) for inReady, return #1 after the accepting edge
    task automatic send(input logic [15:0] d, input logic lst, input logic [1:0] m);
        int waited;
        waited  = 0;
        inData  = d;
        inLast  = lst;
        mode    = m;
        inValid = 1'b1;
        while (!inReady && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!inReady) check("ready_timeout", 32'(inReady), 32'd1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN     = 1'b0;
        mode     = M_AND;
        inData   = '0;
        inValid  = 1'b0;
        inLast   = 1'b0;
        outReady = 1'b1;

        #12;
        check("rst_valid", 32'(outValid), 32'd0);
        check("rst_out",   32'(out), 32'd0);
        check("rst_count", 32'(wordCount), 32'd0);
        check("rst_trunc", 32'(outTrunc), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        #1;
        check("rst_ready", 32'(inReady), 32'd1);
        @(posedge clk);
        #1;

        // 3-beat AND
        send(16'hFFF0, 1'b0, M_AND);
        send(16'h0FFF, 1'b0, M_AND);
        send(16'h3CFF, 1'b1, M_AND);
        check_result("and3", 16'h0CF0, 3, 1'b0);
        check("and3_ready_low", 32'(inReady), 32'd0);
        @(posedge clk);
        #1;
        check("and3_valid_drop", 32'(outValid), 32'd0);
        check("and3_ready_back", 32'(inReady), 32'd1);

        // NAND with mode change on beat 2 ignored
        send(16'hAAAA, 1'b0, M_NAND);
        send(16'hFFFF, 1'b1, M_OR);
        check_result("nand2", 16'h5555, 2, 1'b0);
        @(posedge clk);
        #1;
        check("nand2_valid_drop", 32'(outValid), 32'd0);

        // XOR with back-pressure; a presented beat must not be taken while stalled
        outReady = 1'b0;
        send(16'h1234, 1'b0, M_XOR);
        send(16'h1234, 1'b0, M_XOR);
        send(16'h00FF, 1'b1, M_XOR);
        inData  = 16'hFFFF;
        inLast  = 1'b1;
        mode    = M_AND;
        inValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("xor_hold_valid", 32'(outValid), 32'd1);
            check("xor_hold_out",   32'(out), 32'h00FF);
            check("xor_hold_count", 32'(wordCount), 32'd3);
            check("xor_hold_ready", 32'(inReady), 32'd0);
            @(posedge clk);
            #1;
        end
        outReady = 1'b1;
        inValid  = 1'b0;
        inLast   = 1'b0;
        @(posedge clk);
        #1;
        check("xor_release_valid", 32'(outValid), 32'd0);
        check("xor_release_out",   32'(out), 32'h00FF);
        check("xor_release_count", 32'(wordCount), 32'd3);
        check("xor_release_ready", 32'(inReady), 32'd1);

        // OR forced close at MAX_WORDS, remainder forms a new packet
        send(16'h0001, 1'b0, M_OR);
        send(16'h0002, 1'b0, M_OR);
        send(16'h0004, 1'b0, M_OR);
        send(16'h0008, 1'b0, M_OR);
        check_result("or_trunc", 16'h000F, 4, 1'b1);
        send(16'h0010, 1'b0, M_OR);
        send(16'h0020, 1'b1, M_OR);
        check_result("or_tail", 16'h0030, 2, 1'b0);

        // inLast on the MAX_WORDS-th beat closes normally
        send(16'hFFFF, 1'b0, M_AND);
        send(16'hFF0F, 1'b0, M_AND);
        send(16'hF0FF, 1'b0, M_AND);
        send(16'h7FFF, 1'b1, M_AND);
        check_result("and4_last", 16'h700F, 4, 1'b0);

        // Single-beat packet
        send(16'hBEEF, 1'b1, M_AND);
        check_result("single", 16'hBEEF, 1, 1'b0);

        // Asynchronous reset mid-packet
        send(16'h1111, 1'b0, M_AND);
        send(16'h2222, 1'b0, M_AND);
        #3;
        rstN = 1'b0;
        #1;
        check("arst_out",   32'(out), 32'd0);
        check("arst_valid", 32'(outValid), 32'd0);
        check("arst_count", 32'(wordCount), 32'd0);
        check("arst_trunc", 32'(outTrunc), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        check("arst_no_result", 32'(outValid), 32'd0);
        send(16'h00F0, 1'b1, M_OR);
        check_result("post_rst", 16'h00F0, 1, 1'b0);
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bitwise_reducer.md
Name: bitwise_reducer

Overview:
- Streaming, parametrised successor to the 2-input AND gate.
- Folds a packet of WIDTH-bit words into one result using bitwise AND, OR, XOR or NAND, selected per packet.
- Registered result is presented on a valid/ready output handshake.
- Sits between word-stream producers (ALU/memory test paths) and consumers that need a per-packet bit mask or parity.

Parameters:
- WIDTH, 16, data word width in bits (>=1).
- MAX_WORDS, 16, maximum beats per packet (>=1); a packet is force-closed when it reaches this count.
- CNT_W, $clog2(MAX_WORDS+1), derived localparam (not overridable); width of wordCount.

Ports:
- clk  input  1  system clock, rising-edge.
- rstN  input  1  asynchronous, active-low reset.
- mode  input  2  operation: 0=AND, 1=OR, 2=XOR, 3=NAND. Sampled on the first beat of a packet only.
- inData  input  WIDTH  input word.
- inValid  input  1  inData/inLast/mode valid.
- inLast  input  1  final beat of the packet.
- inReady  output  1  block accepts a beat this cycle.
- out  output  WIDTH  reduced result.
- outValid  output  1  out/wordCount/outTrunc valid.
- outReady  input  1  consumer accepts the result.
- wordCount  output  CNT_W  number of beats folded into out.
- outTrunc  output  1  packet closed by the MAX_WORDS limit, not by inLast.

Behaviour:
- Clock and reset: single clock domain. rstN low asynchronously forces:
  - state=IDLE, out=0, outValid=0, wordCount=0, outTrunc=0, internal accumulator=0, latched mode=0.
  - Reset mid-packet discards the partial packet; no result is emitted for it.
- Beat acceptance: a beat is accepted on a rising edge where inValid && inReady. inReady = (state != DONE), combinational from state only, so inReady=1 in the cycle reset releases.
- Identity value: all ones for AND and NAND; all zeros for OR and XOR.
- State IDLE, on accept:
  - Latch mode.
  - acc = identity OP inData, i.e. acc = inData.
  - cnt = 1.
  - If inLast, or MAX_WORDS==1, go to DONE; otherwise go to ACCUM.
- State ACCUM, on accept:
  - acc = acc OP inData, where NAND accumulates as AND.
  - cnt = cnt+1.
  - If inLast, go to DONE with trunc=0.
  - Else if cnt+1 == MAX_WORDS, go to DONE with trunc=1.
  - Otherwise stay in ACCUM.
  - mode changes while in ACCUM are ignored.
- State ACCUM, no accept: hold acc, cnt and state. There is no timeout.
- Entry to DONE (same edge as the closing beat):
  - out = acc, or ~acc when the latched mode is NAND.
  - wordCount = cnt, outTrunc = trunc, outValid = 1.
- State DONE:
  - inReady=0.
  - out, wordCount and outTrunc stay stable while outValid && !outReady.
  - On outValid && outReady: outValid=0 and state=IDLE on that edge.
  - out, wordCount and outTrunc keep their last values until the next DONE entry.
- Latency:
  - outValid rises on the clock edge that accepts the closing beat, i.e. it is visible in the cycle after that beat.
  - Minimum spacing is one packet per (beats + 1) cycles with outReady tied high, because DONE always costs one cycle.
- Truncated packets: beats that arrive after a forced close, while inLast is still low, start a new packet in IDLE.
- Widths: all operations are bitwise on WIDTH bits. No arithmetic except cnt, which never exceeds MAX_WORDS and so cannot wrap.

Test Plan:
- Reset, then 3-beat AND packet 0xFFF0, 0x0FFF, 0x3CFF (last) with outReady=1 -> out=0x0CF0, wordCount=3, outTrunc=0, outValid high exactly 1 cycle, inReady low only that cycle.
- 2-beat NAND packet 0xAAAA, 0xFFFF (last), with mode driven to 1 on beat 2 -> out=0x5555; mode change ignored.
- XOR packet 0x1234, 0x1234, 0x00FF (last) with outReady=0 for 4 cycles -> out=0x00FF, wordCount=3, held stable, inReady=0 throughout; released one edge after outReady=1.
- OR, MAX_WORDS=4, 6 beats 0x0001, 0x0002, 0x0004, 0x0008, 0x0010, 0x0020 (last on beat 6) -> first result 0x000F, wordCount=4, outTrunc=1; second result 0x0030, wordCount=2, outTrunc=0.
- Single-beat packet 0xBEEF (inLast on first beat, mode=AND) -> out=0xBEEF, wordCount=1.
- rstN pulsed low asynchronously (mid-cycle) after 2 of 3 beats -> outputs 0 immediately, no outValid; next packet 0x00F0 (last, OR) -> out=0x00F0, wordCount=1.
